// File: rtl/ks_pkg.sv
// Shared definitions for the multi-word Kogge-Stone add controller:
// FSM state encoding and default slice geometry.
package ks_pkg;

   localparam int KS_W     = 16;
   localparam int KS_WORDS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ks_state_e;

endpackage

// File: rtl/ks_add16_c.sv
// Combinational W-bit Kogge-Stone prefix adder with carry-in and carry-out.
// Carry-in is folded into bit 0's generate so the prefix tree yields every carry directly.
module ks_add16_c #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int LVLS = $clog2(W);

   logic [W-1:0] p_bit;
   logic [W-1:0] g_bit;
   logic [W-1:0] g_pre;
   logic [W-1:0] p_pre;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_bit_gp
         assign p_bit[gi] = a[gi] ^ b[gi];
         assign g_bit[gi] = a[gi] & b[gi];
      end
   endgenerate

   // Each level doubles the span; positions below the span already hold final group terms.
   always_comb begin
      g_pre = g_bit | {{(W-1){1'b0}}, p_bit[0] & cin};
      p_pre = p_bit;
      for (int l = 0; l < LVLS; l++) begin
         g_pre = g_pre | (p_pre & (g_pre << (1 << l)));
         p_pre = p_pre & ((p_pre << (1 << l)) | ~({W{1'b1}} << (1 << l)));
      end
   end

   assign sum  = p_bit ^ {g_pre[W-2:0], cin};
   assign cout = g_pre[W-1];

endmodule

// File: rtl/ks_mw_add_ctrl.sv
// Two-requester multi-word add/subtract controller: one operation at a time is
// pushed word by word through a single shared W-bit prefix-adder slice.
module ks_mw_add_ctrl
   import ks_pkg::*;
#(
   parameter int W     = KS_W,
   parameter int WORDS = KS_WORDS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [W*WORDS-1:0]   req_a0,
   input  logic [W*WORDS-1:0]   req_b0,
   input  logic [W*WORDS-1:0]   req_a1,
   input  logic [W*WORDS-1:0]   req_b1,
   input  logic [1:0]           req_sub,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [W*WORDS-1:0]   res_sum,
   output logic                 res_cout,
   output logic                 res_id
);

   localparam int N  = W * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef logic [WORDS-1:0][W-1:0] word_vec_t;

   ks_state_e     state_q, state_d;
   word_vec_t     a_q, a_d;
   word_vec_t     b_q, b_d;
   word_vec_t     sum_q, sum_d;
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic          id_q, id_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;

   logic          gnt_any;
   logic          gnt_id;
   logic [N-1:0]  b_sel;
   logic          sub_sel;

   logic [W-1:0]  add_a;
   logic [W-1:0]  add_b;
   logic [W-1:0]  add_sum;
   logic          add_cout;

   // Round-robin on a tie: the requester not granted last time wins.
   always_comb begin
      gnt_any = |req_valid;
      gnt_id  = 1'b0;
      case (req_valid)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~last_q;
         default: gnt_id = 1'b0;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      if ((state_q == ST_IDLE) && !rst && gnt_any) begin
         req_ready = gnt_id ? 2'b10 : 2'b01;
      end
   end

   assign add_a = a_q[k_q];
   assign add_b = b_q[k_q];

   ks_add16_c #(
      .W(W)
   ) u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      k_d     = k_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      id_d    = id_q;
      valid_d = valid_q;
      last_d  = last_q;
      b_sel   = gnt_id ? req_b1 : req_b0;
      sub_sel = gnt_id ? req_sub[1] : req_sub[0];

      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               // Subtract is a + ~b + 1: invert b once here, seed the carry with 1.
               a_d     = gnt_id ? req_a1 : req_a0;
               b_d     = sub_sel ? ~b_sel : b_sel;
               carry_d = sub_sel;
               id_d    = gnt_id;
               last_d  = gnt_id;
               k_d     = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[k_q] = add_sum;
            carry_d    = add_cout;
            k_d        = k_q + KW'(1);
            if (k_q == KW'(WORDS - 1)) begin
               cout_d  = add_cout;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign res_valid = valid_q;
   assign res_sum   = sum_q;
   assign res_cout  = cout_q;
   assign res_id    = id_q;

endmodule
